// File: rtl/signsat.sv
// Narrows a signed M-bit sample to N bits with clamping, behind a one-deep
// valid/ready register stage, and counts how many accepted samples clamped.
module signsat #(
    parameter int M     = 5,
    parameter int N     = 2,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [M-1:0]     i_val,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [N-1:0]     o_val,
    output logic             o_sat,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_ovf_cnt
);

    localparam logic [N-1:0] POS_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] NEG_MIN = {1'b1, {(N-1){1'b0}}};

    logic [M-N:0] upper;
    logic         in_range;
    logic [N-1:0] nar_val;
    logic         nar_sat;
    logic         in_xfer;
    logic         out_xfer;

    // The value fits when every bit from the MSB down to the new sign bit agrees.
    always_comb begin
        upper    = i_val[M-1:N-1];
        in_range = (&upper) || !(|upper);
        nar_val  = i_val[N-1:0];
        nar_sat  = 1'b0;
        if (!in_range) begin
            nar_sat = 1'b1;
            nar_val = i_val[M-1] ? NEG_MIN : POS_MAX;
        end
    end

    assign o_ready  = !o_valid || i_ready;
    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = o_valid && i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_val   <= '0;
            o_sat   <= 1'b0;
        end else if (in_xfer) begin
            o_valid <= 1'b1;
            o_val   <= nar_val;
            o_sat   <= nar_sat;
        end else if (out_xfer) begin
            o_valid <= 1'b0;
            o_val   <= '0;
            o_sat   <= 1'b0;
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ovf_cnt <= '0;
        end else if (i_clr) begin
            o_ovf_cnt <= '0;
        end else if (in_xfer && nar_sat && (o_ovf_cnt != {CNT_W{1'b1}})) begin
            o_ovf_cnt <= o_ovf_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_signsat.sv
// Self-checking bench for signsat: vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_signsat;

    localparam int M = 5;
    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0, ready = 1'b1, clr = 1'b0;
    logic [M-1:0] val = '0;
    logic         o_ready, o_valid, o_sat;
    logic [N-1:0] o_val;
    logic [7:0]   o_cnt;

    logic         valid2 = 1'b0, clr2 = 1'b0;
    logic [M-1:0] val2 = '0;
    logic         o_ready2, o_valid2, o_sat2;
    logic [N-1:0] o_val2;
    logic [1:0]   o_cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    signsat #(.M(M), .N(N), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready),
        .i_val(val), .o_valid(o_valid), .i_ready(ready), .o_val(o_val),
        .o_sat(o_sat), .i_clr(clr), .o_ovf_cnt(o_cnt)
    );

    signsat #(.M(M), .N(N), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid2), .o_ready(o_ready2),
        .i_val(val2), .o_valid(o_valid2), .i_ready(1'b1), .o_val(o_val2),
        .o_sat(o_sat2), .i_clr(clr2), .o_ovf_cnt(o_cnt2)
    );

    typedef struct {
        logic [M-1:0] in_val;
        logic [N-1:0] exp_val;
        logic         exp_sat;
        logic [7:0]   exp_cnt;
    } vec_t;

    vec_t vecs[8];

    // Reference narrowing computed from the signed value with plain integers.
    function automatic void refSat(input logic [M-1:0] v, output logic [N-1:0] o, output logic s);
        int x;
        int maxv;
        int minv;
        int r;
        x    = int'($signed(v));
        maxv = (1 << (N-1)) - 1;
        minv = -(1 << (N-1));
        s    = 1'b1;
        if (x > maxv) r = maxv;
        else if (x < minv) r = minv;
        else begin
            r = x;
            s = 1'b0;
        end
        o = r[N-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [M-1:0] d, input logic r, input logic c);
        valid = v;
        val   = d;
        ready = r;
        clr   = c;
    endtask

    logic [N-1:0] q_val[$];
    logic         q_sat[$];
    int           exp_cnt;

    initial begin
        logic [N-1:0] rv;
        logic         rs;
        logic         in_x, out_x, v, r;
        logic [M-1:0] d;
        int           exp2[5];

        vecs[0] = '{5'b00001, 2'b01, 1'b0, 8'd0};
        vecs[1] = '{5'b11110, 2'b10, 1'b0, 8'd0};
        vecs[2] = '{5'b00101, 2'b01, 1'b1, 8'd1};
        vecs[3] = '{5'b10000, 2'b10, 1'b1, 8'd2};
        vecs[4] = '{5'b00011, 2'b01, 1'b1, 8'd3};
        vecs[5] = '{5'b11111, 2'b11, 1'b0, 8'd3};
        vecs[6] = '{5'b00000, 2'b00, 1'b0, 8'd3};
        vecs[7] = '{5'b11101, 2'b10, 1'b1, 8'd4};

        // Reset state
        #12;
        checkOutput("rst_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_ready", 32'(o_ready), 32'd1);
        checkOutput("rst_val", 32'(o_val), 32'd0);
        checkOutput("rst_cnt", 32'(o_cnt), 32'd0);
        rst_n = 1'b1;

        // Back-to-back table: one result per cycle, in order
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecs[i].in_val, 1'b1, 1'b0);
            tick();
            checkOutput($sformatf("vec%0d_valid", i), 32'(o_valid), 32'd1);
            checkOutput($sformatf("vec%0d_val", i), 32'(o_val), 32'(vecs[i].exp_val));
            checkOutput($sformatf("vec%0d_sat", i), 32'(o_sat), 32'(vecs[i].exp_sat));
            checkOutput($sformatf("vec%0d_cnt", i), 32'(o_cnt), 32'(vecs[i].exp_cnt));
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("drain_valid", 32'(o_valid), 32'd0);
        checkOutput("drain_val", 32'(o_val), 32'd0);
        checkOutput("drain_sat", 32'(o_sat), 32'd0);

        // Backpressure: hold a result, pending saturating sample not accepted
        applyStimulus(1'b1, 5'b00101, 1'b0, 1'b0);
        tick();
        checkOutput("bp_first_valid", 32'(o_valid), 32'd1);
        checkOutput("bp_cnt_a", 32'(o_cnt), 32'd5);
        applyStimulus(1'b1, 5'b10000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_ready_low", 32'(o_ready), 32'd0);
            tick();
            checkOutput("bp_hold_valid", 32'(o_valid), 32'd1);
            checkOutput("bp_hold_val", 32'(o_val), 32'b01);
            checkOutput("bp_hold_sat", 32'(o_sat), 32'd1);
            checkOutput("bp_hold_cnt", 32'(o_cnt), 32'd5);
        end
        ready = 1'b1;
        #1;
        checkOutput("bp_ready_high", 32'(o_ready), 32'd1);
        tick();
        checkOutput("bp_new_valid", 32'(o_valid), 32'd1);
        checkOutput("bp_new_val", 32'(o_val), 32'b10);
        checkOutput("bp_new_sat", 32'(o_sat), 32'd1);
        checkOutput("bp_cnt_b", 32'(o_cnt), 32'd6);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("bp_drain", 32'(o_valid), 32'd0);

        // Clear leaves the data path alone
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        tick();
        checkOutput("clr_cnt", 32'(o_cnt), 32'd0);
        checkOutput("clr_valid", 32'(o_valid), 32'd0);
        clr = 1'b0;

        // Narrow counter saturates at 3, then clear beats a saturating transfer
        exp2 = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) begin
            valid2 = 1'b1;
            val2   = (i % 2 == 0) ? 5'b01000 : 5'b10111;
            tick();
            checkOutput($sformatf("cnt2_step%0d", i), 32'(o_cnt2), 32'(exp2[i]));
        end
        val2 = 5'b01111;
        clr2 = 1'b1;
        tick();
        checkOutput("cnt2_clr", 32'(o_cnt2), 32'd0);
        checkOutput("cnt2_clr_sat", 32'(o_sat2), 32'd1);
        checkOutput("cnt2_clr_val", 32'(o_val2), 32'b01);
        valid2 = 1'b0;
        clr2   = 1'b0;

        // Asynchronous reset while a result is held
        applyStimulus(1'b1, 5'b01010, 1'b0, 1'b0);
        tick();
        checkOutput("ar_pre_valid", 32'(o_valid), 32'd1);
        checkOutput("ar_pre_cnt", 32'(o_cnt), 32'd1);
        valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_valid", 32'(o_valid), 32'd0);
        checkOutput("ar_val", 32'(o_val), 32'd0);
        checkOutput("ar_sat", 32'(o_sat), 32'd0);
        checkOutput("ar_cnt", 32'(o_cnt), 32'd0);
        checkOutput("ar_ready", 32'(o_ready), 32'd1);
        #1;
        applyStimulus(1'b1, 5'b00001, 1'b1, 1'b0);
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_valid", 32'(o_valid), 32'd1);
        checkOutput("post_rst_val", 32'(o_val), 32'b01);
        checkOutput("post_rst_sat", 32'(o_sat), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("post_rst_drain", 32'(o_valid), 32'd0);

        // Randomized traffic against a queue-based model
        exp_cnt = int'(o_cnt);
        checkOutput("rand_start_cnt", 32'(o_cnt), 32'd0);
        for (int i = 0; i < 400; i++) begin
            v = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 3) != 0);
            d = M'($urandom);
            applyStimulus(v, d, r, 1'b0);
            #1;
            checkOutput("rand_ready", 32'(o_ready), 32'((q_val.size() == 0) || r));
            in_x  = v && ((q_val.size() == 0) || r);
            out_x = (q_val.size() != 0) && r;
            if (out_x) begin
                void'(q_val.pop_front());
                void'(q_sat.pop_front());
            end
            if (in_x) begin
                refSat(d, rv, rs);
                q_val.push_back(rv);
                q_sat.push_back(rs);
                if (rs && exp_cnt < 255) exp_cnt++;
            end
            tick();
            checkOutput("rand_valid", 32'(o_valid), 32'(q_val.size() != 0));
            if (q_val.size() != 0) begin
                checkOutput("rand_val", 32'(o_val), 32'(q_val[0]));
                checkOutput("rand_sat", 32'(o_sat), 32'(q_sat[0]));
            end else begin
                checkOutput("rand_idle_val", 32'(o_val), 32'd0);
                checkOutput("rand_idle_sat", 32'(o_sat), 32'd0);
            end
            checkOutput("rand_cnt", 32'(o_cnt), 32'(exp_cnt));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
